// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
//
// UART transmit engine. One byte is held in a Transmit Holding Register
// (THR) and serialised through a Transmit Shift Register (TSR). Each frame is
// a start bit, 8 data bits LSB first, an optional parity bit, and 1 or 2 stop
// bits. THR and TSR together form a double buffer. If THR is already loaded
// when a frame ends, the next frame starts with no idle gap.
//
// Optional build macro: UART_TX_CTS_EN
//   When defined, a new frame starts only while cts_i (active-low) is low,
//   as seen through a 2-flop synchroniser. A frame that has already started
//   always completes. When undefined, cts_i is ignored.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-high
//   thr_push_i    single-cycle strobe that writes thr_byte_i into THR
//   thr_byte_i    byte to transmit
//   thr_full_o    THR holds an unsent byte
//   tx_empty_o    THR empty and no frame in progress
//   tx_busy_o     frame in progress
//   enable_i      transmitter enable; low aborts a frame (THR is kept)
//   brg_sample_i  baud-rate tick, one clk wide
//   brgh_i        1: 4 ticks per bit, 0: 16 ticks per bit
//   pdsel_i       00 none, 01 even, 10 odd, 11 none
//   stsel_i       0: one stop bit, 1: two stop bits
//   cts_i         clear-to-send, active-low (UART_TX_CTS_EN only)
//   txd_o         serial line, registered, idles high
// ---------------------------------------------------------------------------
module uart_transmitter (
    input  logic       clk,
    input  logic       rst,
    input  logic       thr_push_i,
    input  logic [7:0] thr_byte_i,
    output logic       thr_full_o,
    output logic       tx_empty_o,
    output logic       tx_busy_o,
    input  logic       enable_i,
    input  logic       brg_sample_i,
    input  logic       brgh_i,
    input  logic [1:0] pdsel_i,
    input  logic       stsel_i,
    input  logic       cts_i,
    output logic       txd_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } tx_state_t;

    // Returns the parity bit for a byte under the selected parity mode.
    // Modes 00 and 11 carry no parity, so the bit is don't-care and is
    // returned as 0.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
        logic p;
        case (mode)
            2'b01:   p = ^data;
            2'b10:   p = ~^data;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    tx_state_t  state_r, state_next_s;
    logic [7:0] tsr_r, tsr_next_s;
    logic [7:0] thr_r, thr_next_s;
    logic       thr_full_r, thr_full_next_s;
    logic [2:0] bit_cnt_r, bit_cnt_next_s;
    logic [3:0] baud_cnt_r, baud_cnt_next_s;
    logic       par_r, par_next_s;
    logic       txd_r, txd_next_s;
    logic       busy_r, busy_next_s;
    logic       empty_r, empty_next_s;

    logic       bit_end_s;
    logic       cts_ok_s;
    logic       can_load_s;
    logic       load_s;
    logic       push_ok_s;
    logic       parity_en_s;

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_sync_r;

    // Two-flop synchroniser for cts_i. It resets to "not clear".
    always_ff @(posedge clk) begin
        if (rst) begin
            cts_sync_r <= 2'b11;
        end else begin
            cts_sync_r <= {cts_sync_r[0], cts_i};
        end
    end

    assign cts_ok_s = ~cts_sync_r[1];
`else
    logic cts_unused_s;
    assign cts_unused_s = cts_i;
    assign cts_ok_s     = 1'b1;
`endif

    // The bit boundary is the last tick of the current bit period.
    assign bit_end_s   = brg_sample_i & (brgh_i ? (baud_cnt_r[1:0] == 2'd3)
                                                : (baud_cnt_r == 4'd15));
    assign parity_en_s = (pdsel_i == 2'b01) | (pdsel_i == 2'b10);
    // THR may move into TSR: this applies both from IDLE and at a frame end.
    assign can_load_s  = enable_i & thr_full_r & cts_ok_s;

    // Next-state logic. A frame end chains directly into START when THR is loadable.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (can_load_s) begin
                    state_next_s = ST_START;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (!enable_i) begin
                    state_next_s = ST_IDLE;
                end else if (bit_end_s) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (!enable_i) begin
                    state_next_s = ST_IDLE;
                end else if (bit_end_s && (bit_cnt_r == 3'd0)) begin
                    state_next_s = parity_en_s ? ST_PARITY : ST_STOP1;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (!enable_i) begin
                    state_next_s = ST_IDLE;
                end else if (bit_end_s) begin
                    state_next_s = ST_STOP1;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
            ST_STOP1: begin
                if (!enable_i) begin
                    state_next_s = ST_IDLE;
                end else if (bit_end_s && stsel_i) begin
                    state_next_s = ST_STOP2;
                end else if (bit_end_s) begin
                    if (can_load_s) begin
                        state_next_s = ST_START;
                        load_s       = 1'b1;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_STOP1;
                end
            end
            ST_STOP2: begin
                if (!enable_i) begin
                    state_next_s = ST_IDLE;
                end else if (bit_end_s) begin
                    if (can_load_s) begin
                        state_next_s = ST_START;
                        load_s       = 1'b1;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_STOP2;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: TSR load and shift, bit counter, baud counter and parity capture.
    always_comb begin
        tsr_next_s      = tsr_r;
        bit_cnt_next_s  = bit_cnt_r;
        baud_cnt_next_s = baud_cnt_r;
        par_next_s      = par_r;
        if (load_s) begin
            tsr_next_s      = thr_r;
            bit_cnt_next_s  = 3'd7;
            baud_cnt_next_s = 4'd0;
            par_next_s      = parity_bit(thr_r, pdsel_i);
        end else begin
            if ((state_r != ST_IDLE) && brg_sample_i) begin
                baud_cnt_next_s = baud_cnt_r + 4'd1;
            end else begin
                baud_cnt_next_s = baud_cnt_r;
            end
            if ((state_r == ST_DATA) && enable_i && bit_end_s) begin
                tsr_next_s = {1'b0, tsr_r[7:1]};
                if (bit_cnt_r != 3'd0) begin
                    bit_cnt_next_s = bit_cnt_r - 3'd1;
                end else begin
                    bit_cnt_next_s = bit_cnt_r;
                end
            end else begin
                tsr_next_s     = tsr_r;
                bit_cnt_next_s = bit_cnt_r;
            end
        end
    end

    // A push is accepted when THR is free, or when THR is emptied into TSR in the same cycle.
    always_comb begin
        thr_next_s      = thr_r;
        thr_full_next_s = thr_full_r;
        push_ok_s       = thr_push_i & (~thr_full_r | load_s);
        if (push_ok_s) begin
            thr_next_s      = thr_byte_i;
            thr_full_next_s = 1'b1;
        end else if (load_s) begin
            thr_next_s      = thr_r;
            thr_full_next_s = 1'b0;
        end else begin
            thr_next_s      = thr_r;
            thr_full_next_s = thr_full_r;
        end
    end

    // Output values are computed from the next state so that the registered line tracks the FSM.
    always_comb begin
        txd_next_s = 1'b1;
        case (state_next_s)
            ST_IDLE:   txd_next_s = 1'b1;
            ST_START:  txd_next_s = 1'b0;
            ST_DATA:   txd_next_s = tsr_next_s[0];
            ST_PARITY: txd_next_s = par_next_s;
            ST_STOP1:  txd_next_s = 1'b1;
            ST_STOP2:  txd_next_s = 1'b1;
            default:   txd_next_s = 1'b1;
        endcase
        busy_next_s  = (state_next_s != ST_IDLE);
        empty_next_s = ~thr_full_next_s & (state_next_s == ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            tsr_r      <= 8'h00;
            thr_r      <= 8'h00;
            thr_full_r <= 1'b0;
            bit_cnt_r  <= 3'd0;
            baud_cnt_r <= 4'd0;
            par_r      <= 1'b0;
            txd_r      <= 1'b1;
            busy_r     <= 1'b0;
            empty_r    <= 1'b1;
        end else begin
            state_r    <= state_next_s;
            tsr_r      <= tsr_next_s;
            thr_r      <= thr_next_s;
            thr_full_r <= thr_full_next_s;
            bit_cnt_r  <= bit_cnt_next_s;
            baud_cnt_r <= baud_cnt_next_s;
            par_r      <= par_next_s;
            txd_r      <= txd_next_s;
            busy_r     <= busy_next_s;
            empty_r    <= empty_next_s;
        end
    end

    assign txd_o      = txd_r;
    assign thr_full_o = thr_full_r;
    assign tx_busy_o  = busy_r;
    assign tx_empty_o = empty_r;

endmodule
